// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants (XLEN, opcodes, funct3), ALU op enum and ALU/decode helpers
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  function automatic alu_op_e dec_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [XLEN-1:0] alu(input alu_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      default:  return a & b;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_if.sv
// rv32i_if: register-file access bundle (2 read ports ra1/ra2->rd1/rd2, 1 write port we/wa/wd); master=core, slave=regfile
interface rv32i_if;
  import rv32i_pkg::*;
  logic [4:0] ra1, ra2, wa;
  logic [XLEN-1:0] rd1, rd2, wd;
  logic we;
  modport master(output ra1, ra2, wa, wd, we, input rd1, rd2);
  modport slave(input ra1, ra2, wa, wd, we, output rd1, rd2);
endinterface

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32x32 register file (clk, rf slave port), combinational reads, posedge write, x0 pinned to zero
module rv32i_regfile
  import rv32i_pkg::*;
(
  input logic clk,
  rv32i_if.slave rf
);
  logic [XLEN-1:0] data [0:31];
  always_ff @(posedge clk) begin
    if (rf.we && rf.wa != 5'd0) data[rf.wa] <= rf.wd;
    data[0] <= '0;
  end
  assign rf.rd1 = (rf.ra1 == 5'd0) ? '0 : data[rf.ra1];
  assign rf.rd2 = (rf.ra2 == 5'd0) ? '0 : data[rf.ra2];
endmodule

// File: rtl/rv32i_cpu_core.sv
// rv32i_cpu_core: single-cycle RV32I core with unified memory mem; ports clk, rst_n (sync active-low), halt when RV32I_HALT_PORT_EN is defined
module rv32i_cpu_core
  import rv32i_pkg::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n
`ifdef RV32I_HALT_PORT_EN
  , input logic halt
`endif
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] pc, pc_next, instr, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_y, addr, ld_word, ld_val, st_data, wd;
  logic [15:0] hw;
  logic [7:0] byt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [3:0] be;
  logic run, is_ecall, eq, lt, ltu, cond, take, we;
  alu_op_e op;
  rv32i_if rf ();
  rv32i_regfile i_regfile (.clk(clk), .rf(rf));
`ifdef RV32I_HALT_PORT_EN
  assign run = rst_n & ~halt;
`else
  assign run = rst_n;
`endif
  assign instr = mem[pc[AW+1:2]];
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign is_ecall = run && instr == 32'h0000_0073;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rf.ra1 = instr[19:15];
  assign rf.ra2 = instr[24:20];
  // instr[30] selects SUB/SRA for register ops, but only SRAI among immediate ops
  assign op = dec_alu(f3, instr[30] & (opc == OP_OP || f3 == F3_SR));
  assign alu_y = alu(op, rf.rd1, opc == OP_OP ? rf.rd2 : imm_i);
  assign eq = rf.rd1 == rf.rd2;
  assign lt = $signed(rf.rd1) < $signed(rf.rd2);
  assign ltu = rf.rd1 < rf.rd2;
  // funct3[2:1] picks the comparison, funct3[0] inverts it; funct3 2/3 never branch
  assign cond = f3[2] ? (f3[1] ? ltu : lt) : eq;
  assign take = (f3[2] || f3[1] == 1'b0) && (cond ^ f3[0]);
  assign addr = rf.rd1 + (opc == OP_STORE ? imm_s : imm_i);
  assign ld_word = mem[addr[AW+1:2]];
  assign byt = ld_word[8*addr[1:0] +: 8];
  assign hw = addr[1] ? ld_word[31:16] : ld_word[15:0];
  assign ld_val = f3[1:0] == 2'b00 ? {{24{~f3[2] & byt[7]}}, byt} :
                  f3[1:0] == 2'b01 ? {{16{~f3[2] & hw[15]}}, hw} : ld_word;
  assign st_data = f3 == F3_B ? {4{rf.rd2[7:0]}} : f3 == F3_H ? {2{rf.rd2[15:0]}} : rf.rd2;
  assign be = f3 == F3_B ? 4'b0001 << addr[1:0] : f3 == F3_H ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = opc == OP_LUI ? imm_u :
              opc == OP_AUIPC ? pc + imm_u :
              (opc == OP_JAL || opc == OP_JALR) ? pc + 32'd4 :
              opc == OP_LOAD ? ld_val :
              (opc == OP_IMM || opc == OP_OP) ? alu_y : '0;
  // CSR forms (funct3 != 0) write rd with zero; ECALL/EBREAK/MRET write nothing
  assign we = run && (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP} ||
                      (opc == OP_SYSTEM && f3 != 3'd0));
  assign rf.we = we;
  assign rf.wa = instr[11:7];
  assign rf.wd = wd;
  assign pc_next = opc == OP_JAL ? pc + imm_j :
                   opc == OP_JALR ? (rf.rd1 + imm_i) & ~32'd1 :
                   (opc == OP_BRANCH && take) ? pc + imm_b : pc + 32'd4;
  always_ff @(posedge clk)
    if (!rst_n) pc <= RESET_PC;
    else if (run) pc <= pc_next;
  always_ff @(posedge clk)
    if (run && opc == OP_STORE)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr[AW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
endmodule

// File: tb/tb_rv32i_cpu_core.sv
// tb_rv32i_cpu_core: directed program run on rv32i_cpu_core with per-step checks of pc, registers, memory and is_ecall
module tb_rv32i_cpu_core;
  import rv32i_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
`ifdef RV32I_HALT_PORT_EN
  logic halt = 1'b0;
  rv32i_cpu_core dut (.clk(clk), .rst_n(rst_n), .halt(halt));
`else
  rv32i_cpu_core dut (.clk(clk), .rst_n(rst_n));
`endif
  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] u_t(int imm, int rd, logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OP_JAL};
  endfunction
  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_OP};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) dut.mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.i_regfile.data[i] = 32'd0;
    dut.i_regfile.data[1] = 32'h0000_A5A5;
    dut.i_regfile.data[7] = 32'h0000_0055;
    dut.mem[0]  = i_t(5, 0, 0, 1, OP_IMM);
    dut.mem[1]  = u_t(32'h12345, 2, OP_LUI);
    dut.mem[2]  = i_t(32'h678, 2, 0, 2, OP_IMM);
    dut.mem[3]  = i_t(-1, 0, 0, 3, OP_IMM);
    dut.mem[4]  = i_t(28, 3, 5, 4, OP_IMM);
    dut.mem[5]  = i_t(32'h400 | 28, 3, 5, 5, OP_IMM);
    dut.mem[6]  = b_t(8, 0, 0, 0);
    dut.mem[7]  = i_t(99, 0, 0, 8, OP_IMM);
    dut.mem[8]  = j_t(16, 1);
    dut.mem[9]  = r_t(0, 3, 0, 3, 6);
    dut.mem[10] = j_t(12, 0);
    dut.mem[12] = i_t(1, 1, 0, 0, OP_JALR);
    dut.mem[13] = u_t(32'hDEADC, 9, OP_LUI);
    dut.mem[14] = i_t(-273, 9, 0, 9, OP_IMM);
    dut.mem[15] = i_t(256, 0, 0, 10, OP_IMM);
    dut.mem[16] = s_t(0, 9, 10, 2);
    dut.mem[17] = i_t(0, 10, 2, 11, OP_LOAD);
    dut.mem[18] = i_t(3, 10, 0, 12, OP_LOAD);
    dut.mem[19] = i_t(3, 10, 4, 13, OP_LOAD);
    dut.mem[20] = i_t(2, 10, 1, 14, OP_LOAD);
    dut.mem[21] = i_t(17, 0, 0, 15, OP_IMM);
    dut.mem[22] = s_t(1, 15, 10, 0);
    dut.mem[23] = i_t(7, 0, 0, 0, OP_IMM);
    dut.mem[24] = i_t(1, 0, 0, 3, OP_IMM);
    dut.mem[25] = 32'h0000_0073;
    dut.mem[26] = i_t(32'hF14, 0, 2, 7, OP_SYSTEM);
    dut.mem[27] = 32'hFFFF_FFFF;
    dut.mem[28] = j_t(0, 0);
    repeat (10) step();
    chk("reset_pc", dut.pc, 32'h0);
    chk("reset_x1_kept", dut.i_regfile.data[1], 32'h0000_A5A5);
    chk("reset_no_ecall", {31'd0, dut.is_ecall}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("addi_x1", dut.i_regfile.data[1], 32'd5);
    chk("pc_after_first", dut.pc, 32'h4);
    step(); step();
    chk("lui_addi_x2", dut.i_regfile.data[2], 32'h1234_5678);
    step();
    chk("addi_neg_x3", dut.i_regfile.data[3], 32'hFFFF_FFFF);
    step();
    chk("srli_x4", dut.i_regfile.data[4], 32'h0000_000F);
    step();
    chk("srai_x5", dut.i_regfile.data[5], 32'hFFFF_FFFF);
    step();
    chk("beq_taken_pc", dut.pc, 32'h20);
    step();
    chk("jal_link_x1", dut.i_regfile.data[1], 32'h24);
    chk("jal_pc", dut.pc, 32'h30);
    step();
    chk("jalr_pc", dut.pc, 32'h24);
    step();
    chk("sltu_x6", dut.i_regfile.data[6], 32'd1);
    step();
    chk("jal_x0_pc", dut.pc, 32'h34);
    chk("skipped_x8", dut.i_regfile.data[8], 32'd0);
`ifdef RV32I_HALT_PORT_EN
    halt = 1'b1;
    repeat (5) step();
    chk("halt_pc", dut.pc, 32'h34);
    chk("halt_x9", dut.i_regfile.data[9], 32'd0);
    halt = 1'b0;
`endif
    step(); step();
    chk("lui_addi_x9", dut.i_regfile.data[9], 32'hDEAD_BEEF);
    step(); step();
    chk("sw_word", dut.mem[64], 32'hDEAD_BEEF);
    step();
    chk("lw_after_sw", dut.i_regfile.data[11], 32'hDEAD_BEEF);
    step();
    chk("lb_103", dut.i_regfile.data[12], 32'hFFFF_FFDE);
    step();
    chk("lbu_103", dut.i_regfile.data[13], 32'h0000_00DE);
    step();
    chk("lh_102", dut.i_regfile.data[14], 32'hFFFF_DEAD);
    step(); step();
    chk("sb_101", dut.mem[64], 32'hDEAD_11EF);
    step();
    chk("x0_held", dut.i_regfile.data[0], 32'd0);
    chk("pre_ecall_low", {31'd0, dut.is_ecall}, 32'd0);
    step();
    chk("ecall_high", {31'd0, dut.is_ecall}, 32'd1);
    chk("ecall_x3", dut.i_regfile.data[3], 32'd1);
    step();
    chk("post_ecall_low", {31'd0, dut.is_ecall}, 32'd0);
    chk("ecall_pc", dut.pc, 32'h68);
    step();
    chk("csrrs_x7", dut.i_regfile.data[7], 32'd0);
    step();
    chk("illegal_pc", dut.pc, 32'h70);
    step();
    chk("loop_pc", dut.pc, 32'h70);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
